// File: rtl/idex_block_pkg.sv
// idex_block_pkg: shared opcodes, ALU codes, operand-select encodings and bubble defaults
package idex_block_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_UPPER = 2'b10;
    localparam logic [1:0] SRCB_FOUR  = 2'b11;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_value;
        logic [XLEN-1:0] rs2_value;
        logic [4:0]      rd;
        alu_op_e         alu;
        logic            src_a;
        logic [1:0]      src_b;
        logic            mem_to_reg;
        logic            reb;
        logic            web;
        logic            reg_write;
        logic [XLEN-1:0] ls_addr;
        logic [XLEN-1:0] ctl_addr;
        logic [XLEN-1:0] upper;
    } idex_t;
    localparam idex_t IDEX_BUBBLE = '{
        pc: '0, rs1_value: '0, rs2_value: '0, rd: '0, alu: ALU_ADD,
        src_a: 1'b0, src_b: SRCB_RS2, mem_to_reg: 1'b0, reb: 1'b1, web: 1'b1,
        reg_write: 1'b0, ls_addr: '0, ctl_addr: '0, upper: '0
    };
    // SUB only exists for register-register ops; the shift-right arithmetic bit applies to both
    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic f7b5, input logic allow_sub);
        case (f3)
            3'b000:  alu_decode = (allow_sub && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_decode = ALU_SLL;
            3'b010:  alu_decode = ALU_SLT;
            3'b011:  alu_decode = ALU_SLTU;
            3'b100:  alu_decode = ALU_XOR;
            3'b101:  alu_decode = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_decode = ALU_OR;
            default: alu_decode = ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/idex_block_regfile.sv
// idex_block_regfile: 2-read/1-write register file with x0 tied to zero and write-through reads
module idex_block_regfile
    import idex_block_pkg::*;
#(
    parameter int XLEN_P = XLEN,
    parameter int NREG_P = NREG,
    localparam int AW = $clog2(NREG_P)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [XLEN_P-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr1,
    input  logic [AW-1:0]     i_raddr2,
    output logic [XLEN_P-1:0] o_rdata1,
    output logic [XLEN_P-1:0] o_rdata2
);
    logic [XLEN_P-1:0] r_mem [NREG_P];
    logic              w_wen;
    assign w_wen = i_we && (i_waddr != '0);
    // reset clears every entry; x0 writes are dropped so entry 0 stays zero
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREG_P; i++) r_mem[i] <= '0;
        end else if (w_wen) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end
    assign o_rdata1 = (i_raddr1 == '0) ? '0 : (w_wen && i_waddr == i_raddr1) ? i_wdata : r_mem[i_raddr1];
    assign o_rdata2 = (i_raddr2 == '0) ? '0 : (w_wen && i_waddr == i_raddr2) ? i_wdata : r_mem[i_raddr2];
endmodule

// File: rtl/idex_block.sv
// idex_block: RV32I decode stage with register file and ID/EX pipeline register
module idex_block
    import idex_block_pkg::*;
#(
    parameter int XLEN_P = XLEN,
    parameter int NREG_P = NREG
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [XLEN_P-1:0] InPC,
    input  logic [31:0]       Inst,
    input  logic              Flush,
    input  logic              WBregWrite,
    input  logic [4:0]        WBrd,
    input  logic [XLEN_P-1:0] WBData,
    output logic [XLEN_P-1:0] PC,
    output logic [XLEN_P-1:0] rs1_value,
    output logic [XLEN_P-1:0] rs2_value,
    output logic [4:0]        rd,
    output logic [3:0]        ALUControl,
    output logic              ALUSourceA,
    output logic [1:0]        ALUSourceB,
    output logic              Dmem1ALUOUT,
    output logic              DmemREB,
    output logic              DmemWEB,
    output logic              IDEXregWrite,
    output logic [XLEN_P-1:0] LoadStore32Address,
    output logic [XLEN_P-1:0] LoadStoreOrjalAddress,
    output logic [XLEN_P-1:0] auipcOrlui
);
    logic [6:0]        w_op;
    logic [2:0]        w_f3;
    logic [XLEN_P-1:0] w_rdata1, w_rdata2, w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;
    logic              w_valid;
    idex_t             w_nxt, r_q;
    assign w_op    = Inst[6:0];
    assign w_f3    = Inst[14:12];
    assign w_imm_i = {{20{Inst[31]}}, Inst[31:20]};
    assign w_imm_s = {{20{Inst[31]}}, Inst[31:25], Inst[11:7]};
    assign w_imm_b = {{19{Inst[31]}}, Inst[31], Inst[7], Inst[30:25], Inst[11:8], 1'b0};
    assign w_imm_j = {{11{Inst[31]}}, Inst[31], Inst[19:12], Inst[20], Inst[30:21], 1'b0};
    assign w_imm_u = {Inst[31:12], 12'b0};
    idex_block_regfile #(.XLEN_P(XLEN_P), .NREG_P(NREG_P)) u_regfile (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_we     (WBregWrite),
        .i_waddr  (WBrd),
        .i_wdata  (WBData),
        .i_raddr1 (Inst[19:15]),
        .i_raddr2 (Inst[24:20]),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2)
    );
    // decode the captured instruction; flushed or unknown opcodes collapse to a bubble
    always_comb begin
        w_nxt           = IDEX_BUBBLE;
        w_valid         = 1'b1;
        w_nxt.pc        = InPC;
        w_nxt.rs1_value = w_rdata1;
        w_nxt.rs2_value = w_rdata2;
        w_nxt.rd        = Inst[11:7];
        w_nxt.upper     = w_imm_u;
        w_nxt.ls_addr   = (w_op == OP_STORE) ? w_imm_s : w_imm_i;
        w_nxt.ctl_addr  = (w_op == OP_JAL) ? w_imm_j : (w_op == OP_BRANCH) ? w_imm_b : w_nxt.ls_addr;
        case (w_op)
            OP_REG: begin
                w_nxt.alu       = alu_decode(w_f3, Inst[30], 1'b1);
                w_nxt.reg_write = 1'b1;
            end
            OP_IMM: begin
                w_nxt.alu       = alu_decode(w_f3, Inst[30], 1'b0);
                w_nxt.src_b     = SRCB_IMM;
                w_nxt.reg_write = 1'b1;
            end
            OP_LOAD: begin
                w_nxt.src_b      = SRCB_IMM;
                w_nxt.reb        = 1'b0;
                w_nxt.mem_to_reg = 1'b1;
                w_nxt.reg_write  = 1'b1;
            end
            OP_STORE: begin
                w_nxt.src_b = SRCB_IMM;
                w_nxt.web   = 1'b0;
            end
            OP_BRANCH: w_nxt.alu = ALU_SUB;
            OP_LUI: begin
                w_nxt.alu       = ALU_PASSB;
                w_nxt.src_b     = SRCB_UPPER;
                w_nxt.reg_write = 1'b1;
            end
            OP_AUIPC: begin
                w_nxt.src_a     = 1'b1;
                w_nxt.src_b     = SRCB_UPPER;
                w_nxt.reg_write = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                w_nxt.src_a     = 1'b1;
                w_nxt.src_b     = SRCB_FOUR;
                w_nxt.reg_write = 1'b1;
            end
            default: w_valid = 1'b0;
        endcase
        if (!w_nxt.reg_write) w_nxt.rd = '0;
        if (Flush || !w_valid) w_nxt = IDEX_BUBBLE;
    end
    // ID/EX pipeline register; reset takes priority over everything
    always_ff @(posedge CLK) begin
        if (RST) r_q <= IDEX_BUBBLE;
        else     r_q <= w_nxt;
    end
    assign PC                    = r_q.pc;
    assign rs1_value             = r_q.rs1_value;
    assign rs2_value             = r_q.rs2_value;
    assign rd                    = r_q.rd;
    assign ALUControl            = r_q.alu;
    assign ALUSourceA            = r_q.src_a;
    assign ALUSourceB            = r_q.src_b;
    assign Dmem1ALUOUT           = r_q.mem_to_reg;
    assign DmemREB               = r_q.reb;
    assign DmemWEB               = r_q.web;
    assign IDEXregWrite          = r_q.reg_write;
    assign LoadStore32Address    = r_q.ls_addr;
    assign LoadStoreOrjalAddress = r_q.ctl_addr;
    assign auipcOrlui            = r_q.upper;
endmodule

// File: tb/tb_idex_block.sv
// tb_idex_block: directed self-checking bench for the decode stage and ID/EX register
module tb_idex_block;
    logic        CLK = 1'b0, RST = 1'b1, Flush = 1'b0, WBregWrite = 1'b0;
    logic [31:0] InPC = '0, Inst = 32'h00500093, WBData = '0;
    logic [4:0]  WBrd = '0;
    logic [31:0] PC, rs1_value, rs2_value, LoadStore32Address, LoadStoreOrjalAddress, auipcOrlui;
    logic [4:0]  rd;
    logic [3:0]  ALUControl;
    logic        ALUSourceA, Dmem1ALUOUT, DmemREB, DmemWEB, IDEXregWrite;
    logic [1:0]  ALUSourceB;
    logic [15:0] ctl;
    logic [207:0] all_out, bubble;
    int n_tests = 0, n_fail = 0;

    idex_block dut (
        .CLK(CLK), .RST(RST), .InPC(InPC), .Inst(Inst), .Flush(Flush),
        .WBregWrite(WBregWrite), .WBrd(WBrd), .WBData(WBData),
        .PC(PC), .rs1_value(rs1_value), .rs2_value(rs2_value), .rd(rd),
        .ALUControl(ALUControl), .ALUSourceA(ALUSourceA), .ALUSourceB(ALUSourceB),
        .Dmem1ALUOUT(Dmem1ALUOUT), .DmemREB(DmemREB), .DmemWEB(DmemWEB),
        .IDEXregWrite(IDEXregWrite), .LoadStore32Address(LoadStore32Address),
        .LoadStoreOrjalAddress(LoadStoreOrjalAddress), .auipcOrlui(auipcOrlui)
    );

    always #5 CLK = ~CLK;

    assign ctl = {rd, ALUControl, ALUSourceA, ALUSourceB, Dmem1ALUOUT, DmemREB, DmemWEB, IDEXregWrite};
    assign all_out = {PC, rs1_value, rs2_value, ctl, LoadStore32Address, LoadStoreOrjalAddress, auipcOrlui};
    assign bubble = {96'b0, 5'd0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 96'b0};

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; tick();
        RST = 1'b0; Inst = 32'h00038433; WBregWrite = 1'b1; WBrd = 5'd7; WBData = 32'h55;
        tick();
        WBregWrite = 1'b0; tick();
        n_tests++; if (rs1_value !== 32'h55) begin n_fail++; $display("FAIL rf_store_x7: got %h want %h", rs1_value, 32'h55); end
        RST = 1'b1; Inst = 32'h00500093; InPC = 32'h40; tick(); tick();
        n_tests++; if (all_out !== bubble) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", all_out, bubble); end
        RST = 1'b0; Inst = 32'h00038433; tick();
        n_tests++; if (rs1_value !== 32'h0) begin n_fail++; $display("FAIL reset_clears_rf: got %h want %h", rs1_value, 32'h0); end
    endtask

    task automatic test_alu_imm();
        Inst = 32'h00500093; InPC = 32'h10; tick();
        n_tests++; if (ctl !== {5'd1, 4'd0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1}) begin n_fail++; $display("FAIL addi_ctl: got %h want %h", ctl, {5'd1, 4'd0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1}); end
        n_tests++; if (PC !== 32'h10) begin n_fail++; $display("FAIL addi_pc: got %h want %h", PC, 32'h10); end
        n_tests++; if (LoadStore32Address !== 32'h5) begin n_fail++; $display("FAIL addi_imm: got %h want %h", LoadStore32Address, 32'h5); end
        n_tests++; if (LoadStoreOrjalAddress !== 32'h5) begin n_fail++; $display("FAIL addi_ctladdr: got %h want %h", LoadStoreOrjalAddress, 32'h5); end
        n_tests++; if (auipcOrlui !== 32'h00500000) begin n_fail++; $display("FAIL addi_upper: got %h want %h", auipcOrlui, 32'h00500000); end
        Inst = 32'h4030D093; tick();
        n_tests++; if (ctl !== {5'd1, 4'd7, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1}) begin n_fail++; $display("FAIL srai_ctl: got %h want %h", ctl, {5'd1, 4'd7, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1}); end
    endtask

    task automatic test_load_store();
        Inst = 32'hFFC0A103; tick();
        n_tests++; if (ctl !== {5'd2, 4'd0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1}) begin n_fail++; $display("FAIL lw_ctl: got %h want %h", ctl, {5'd2, 4'd0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1}); end
        n_tests++; if (LoadStore32Address !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL lw_imm: got %h want %h", LoadStore32Address, 32'hFFFFFFFC); end
        Inst = 32'h0020A423; tick();
        n_tests++; if (ctl !== {5'd0, 4'd0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0}) begin n_fail++; $display("FAIL sw_ctl: got %h want %h", ctl, {5'd0, 4'd0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0}); end
        n_tests++; if (LoadStore32Address !== 32'h8) begin n_fail++; $display("FAIL sw_imm: got %h want %h", LoadStore32Address, 32'h8); end
    endtask

    task automatic test_upper_jump();
        Inst = 32'h123451B7; tick();
        n_tests++; if (ctl !== {5'd3, 4'd10, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1}) begin n_fail++; $display("FAIL lui_ctl: got %h want %h", ctl, {5'd3, 4'd10, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1}); end
        n_tests++; if (auipcOrlui !== 32'h12345000) begin n_fail++; $display("FAIL lui_upper: got %h want %h", auipcOrlui, 32'h12345000); end
        n_tests++; if (LoadStore32Address !== 32'h123) begin n_fail++; $display("FAIL lui_iimm: got %h want %h", LoadStore32Address, 32'h123); end
        Inst = 32'h00001217; tick();
        n_tests++; if (ctl !== {5'd4, 4'd0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1}) begin n_fail++; $display("FAIL auipc_ctl: got %h want %h", ctl, {5'd4, 4'd0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1}); end
        n_tests++; if (auipcOrlui !== 32'h00001000) begin n_fail++; $display("FAIL auipc_upper: got %h want %h", auipcOrlui, 32'h00001000); end
        Inst = 32'h010000EF; tick();
        n_tests++; if (ctl !== {5'd1, 4'd0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1}) begin n_fail++; $display("FAIL jal_ctl: got %h want %h", ctl, {5'd1, 4'd0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1}); end
        n_tests++; if (LoadStoreOrjalAddress !== 32'h10) begin n_fail++; $display("FAIL jal_off: got %h want %h", LoadStoreOrjalAddress, 32'h10); end
        Inst = 32'h004100E7; tick();
        n_tests++; if (ctl !== {5'd1, 4'd0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1}) begin n_fail++; $display("FAIL jalr_ctl: got %h want %h", ctl, {5'd1, 4'd0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1}); end
        n_tests++; if (LoadStoreOrjalAddress !== 32'h4) begin n_fail++; $display("FAIL jalr_off: got %h want %h", LoadStoreOrjalAddress, 32'h4); end
    endtask

    task automatic test_branch();
        Inst = 32'h00208463; tick();
        n_tests++; if (ctl !== {5'd0, 4'd1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL beq_ctl: got %h want %h", ctl, {5'd0, 4'd1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0}); end
        n_tests++; if (LoadStoreOrjalAddress !== 32'h8) begin n_fail++; $display("FAIL beq_off: got %h want %h", LoadStoreOrjalAddress, 32'h8); end
        n_tests++; if (LoadStore32Address !== 32'h2) begin n_fail++; $display("FAIL beq_iimm: got %h want %h", LoadStore32Address, 32'h2); end
    endtask

    task automatic test_regfile();
        Inst = 32'h00028333; WBregWrite = 1'b1; WBrd = 5'd5; WBData = 32'hDEADBEEF; tick();
        WBregWrite = 1'b0;
        n_tests++; if (rs1_value !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wb_forward: got %h want %h", rs1_value, 32'hDEADBEEF); end
        n_tests++; if (ctl !== {5'd6, 4'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1}) begin n_fail++; $display("FAIL add_ctl: got %h want %h", ctl, {5'd6, 4'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1}); end
        Inst = 32'h40528333; tick();
        n_tests++; if (ALUControl !== 4'd1) begin n_fail++; $display("FAIL sub_alu: got %0d want %0d", ALUControl, 1); end
        n_tests++; if ({rs1_value, rs2_value} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin n_fail++; $display("FAIL rf_stored: got %h want %h", {rs1_value, rs2_value}, {32'hDEADBEEF, 32'hDEADBEEF}); end
        Inst = 32'h00000333; WBregWrite = 1'b1; WBrd = 5'd0; WBData = 32'h1234; tick();
        WBregWrite = 1'b0;
        n_tests++; if (rs1_value !== 32'h0) begin n_fail++; $display("FAIL x0_forward: got %h want %h", rs1_value, 32'h0); end
        tick();
        n_tests++; if (rs1_value !== 32'h0) begin n_fail++; $display("FAIL x0_stored: got %h want %h", rs1_value, 32'h0); end
    endtask

    task automatic test_bubble();
        Inst = 32'h0020A423; InPC = 32'h80; Flush = 1'b1; tick();
        Flush = 1'b0;
        n_tests++; if (all_out !== bubble) begin n_fail++; $display("FAIL flush_bubble: got %h want %h", all_out, bubble); end
        Inst = 32'h0000007F; tick();
        n_tests++; if (all_out !== bubble) begin n_fail++; $display("FAIL badop_bubble: got %h want %h", all_out, bubble); end
        Inst = 32'h0020A423; tick();
        n_tests++; if ({PC, DmemWEB} !== {32'h80, 1'b0}) begin n_fail++; $display("FAIL after_bubble: got %h want %h", {PC, DmemWEB}, {32'h80, 1'b0}); end
        Inst = 32'h00500093; Flush = 1'b1; RST = 1'b1; tick();
        RST = 1'b0; Flush = 1'b0;
        n_tests++; if (all_out !== bubble) begin n_fail++; $display("FAIL reset_flush: got %h want %h", all_out, bubble); end
    endtask

    initial begin
        test_reset();
        test_alu_imm();
        test_load_store();
        test_upper_jump();
        test_branch();
        test_regfile();
        test_bubble();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
